// File: rtl/prince_pkg.sv
// rtl/prince_pkg.sv - shared PRINCE S-box tables, lookup function and layer FSM states
//
// Purpose: constants and helpers shared by the PRINCE S-box layer files.
//   SBOX / SBOX_INV     forward and inverse 4-bit S-box, indexed by input nibble
//   prince_sbox()       nibble lookup, dec=0 forward, dec=1 inverse
//   sbox_layer_state_t  IDLE / BUSY / DONE states of the sequential layer

package prince_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sbox_layer_state_t;

  localparam logic [3:0] SBOX [16] = '{
    4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
    4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
    4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1
  };

  function automatic logic [3:0] prince_sbox(input logic [3:0] nib, input logic dec);
    prince_sbox = dec ? SBOX_INV[nib] : SBOX[nib];
  endfunction

endpackage

// File: rtl/prince_sbox_lane.sv
// rtl/prince_sbox_lane.sv - one combinational PRINCE S-box lane
//
// Purpose: substitutes a single nibble.
// Ports:
//   a  in   4  input nibble
//   d  in   1  0 = forward S-box, 1 = inverse S-box
//   y  out  4  substituted nibble

module prince_sbox_lane
  import prince_pkg::*;
(
  input  logic [3:0] a,
  input  logic       d,
  output logic [3:0] y
);

  assign y = prince_sbox(a, d);

endmodule

// File: rtl/prince_sbox_layer.sv
// rtl/prince_sbox_layer.sv - sequential PRINCE S-box layer, LANES nibbles per cycle
//
// Purpose: applies the forward or inverse S-box to every nibble of a
//   4*NIBBLES-bit state over NIBBLES/LANES cycles, using LANES lanes.
// Parameters:
//   NIBBLES  nibbles in the state
//   LANES    S-box lanes per cycle; LANES >= 1 and must divide NIBBLES
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous active-high reset
//   in_valid   in   1          operand valid
//   in_ready   out  1          operand accepted this cycle
//   in_dec     in   1          0 = forward, 1 = inverse; sampled with the operand
//   in_data    in   [0:4N-1]   state, nibble i = bits [4i:4i+3], nibble 0 is MSB
//   out_valid  out  1          result valid
//   out_ready  in   1          downstream accepts the result
//   out_data   out  [0:4N-1]   substituted state, same nibble order

module prince_sbox_layer #(
  parameter int NIBBLES = 16,
  parameter int LANES   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_dec,
  input  logic [0:4*NIBBLES-1]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:4*NIBBLES-1]   out_data
);

  import prince_pkg::*;

  localparam int W       = 4 * NIBBLES;
  localparam int LANES_S = (LANES < 1) ? 1 : LANES;
  localparam int GROUPS  = NIBBLES / LANES_S;
  localparam int CW      = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

  if (LANES < 1 || (NIBBLES % LANES_S) != 0) begin : g_bad_params
    $error("prince_sbox_layer: LANES must be >= 1 and divide NIBBLES");
  end

  sbox_layer_state_t state_q;
  logic [0:W-1]      st_q;
  logic [0:W-1]      st_rot;
  logic              mode_q;
  logic [CW-1:0]     cnt_q;
  logic [3:0]        lane_y [LANES_S];

  // Lanes always work on the head of the register; rotation brings the
  // next group of nibbles to the head each cycle.
  for (genvar l = 0; l < LANES_S; l++) begin : g_lane
    prince_sbox_lane u_lane (
      .a (st_q[4*l +: 4]),
      .d (mode_q),
      .y (lane_y[l])
    );
  end

  // Rotate left by one group; the freshly substituted head lands at the tail,
  // so after GROUPS cycles every nibble is substituted and back in place.
  for (genvar i = 0; i < NIBBLES; i++) begin : g_rot
    if (i < NIBBLES - LANES_S) begin : g_shift
      assign st_rot[4*i +: 4] = st_q[4*(i+LANES_S) +: 4];
    end else begin : g_tail
      assign st_rot[4*i +: 4] = lane_y[i-(NIBBLES-LANES_S)];
    end
  end

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_data = st_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      st_q      <= '0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            st_q    <= in_data;
            mode_q  <= in_dec;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          st_q  <= st_rot;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q   <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              st_q    <= in_data;
              mode_q  <= in_dec;
              cnt_q   <= '0;
              state_q <= BUSY;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prince_sbox_layer.sv
// tb/tb_prince_sbox_layer.sv - self-checking bench for prince_sbox_layer

module tb_prince_sbox_layer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: (16,4)  1: (16,1)  2: (16,16)  3: (8,2)
  logic d0_iv = 0, d0_ir, d0_id = 0, d0_ov, d0_ordy = 0;
  logic d1_iv = 0, d1_ir, d1_id = 0, d1_ov, d1_ordy = 0;
  logic d2_iv = 0, d2_ir, d2_id = 0, d2_ov, d2_ordy = 0;
  logic d3_iv = 0, d3_ir, d3_id = 0, d3_ov, d3_ordy = 0;
  logic [0:63] d0_idat = '0, d0_odat, d1_idat = '0, d1_odat, d2_idat = '0, d2_odat;
  logic [0:31] d3_idat = '0, d3_odat;

  prince_sbox_layer #(.NIBBLES(16), .LANES(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(d0_iv), .in_ready(d0_ir), .in_dec(d0_id),
    .in_data(d0_idat), .out_valid(d0_ov), .out_ready(d0_ordy), .out_data(d0_odat));
  prince_sbox_layer #(.NIBBLES(16), .LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(d1_iv), .in_ready(d1_ir), .in_dec(d1_id),
    .in_data(d1_idat), .out_valid(d1_ov), .out_ready(d1_ordy), .out_data(d1_odat));
  prince_sbox_layer #(.NIBBLES(16), .LANES(16)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(d2_iv), .in_ready(d2_ir), .in_dec(d2_id),
    .in_data(d2_idat), .out_valid(d2_ov), .out_ready(d2_ordy), .out_data(d2_odat));
  prince_sbox_layer #(.NIBBLES(8), .LANES(2)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(d3_iv), .in_ready(d3_ir), .in_dec(d3_id),
    .in_data(d3_idat), .out_valid(d3_ov), .out_ready(d3_ordy), .out_data(d3_odat));

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] fwd_t = 64'hBF32AC916780E5D4;
  logic [63:0] inv_t = 64'hB732FD89A6405EC1;

  // Reference: table lookup per nibble, nibble 0 at the most significant end.
  function automatic logic [63:0] model(logic [63:0] x, int nib, logic dec);
    logic [63:0] t, r;
    int v, s;
    t = dec ? inv_t : fwd_t;
    r = '0;
    for (int i = 0; i < nib; i++) begin
      v = int'((x >> (4*(nib-1-i))) & 64'hF);
      s = int'((t >> (4*(15-v))) & 64'hF);
      r = r | (64'(s) << (4*(nib-1-i)));
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic v, input logic dec, input logic [63:0] d,
                       input logic ordy);
    case (k)
      0: begin d0_iv = v; d0_id = dec; d0_idat = d; d0_ordy = ordy; end
      1: begin d1_iv = v; d1_id = dec; d1_idat = d; d1_ordy = ordy; end
      2: begin d2_iv = v; d2_id = dec; d2_idat = d; d2_ordy = ordy; end
      default: begin d3_iv = v; d3_id = dec; d3_idat = d[31:0]; d3_ordy = ordy; end
    endcase
  endtask

  function automatic logic get_ov(int k);
    case (k)
      0: return d0_ov;
      1: return d1_ov;
      2: return d2_ov;
      default: return d3_ov;
    endcase
  endfunction

  function automatic logic get_ir(int k);
    case (k)
      0: return d0_ir;
      1: return d1_ir;
      2: return d2_ir;
      default: return d3_ir;
    endcase
  endfunction

  function automatic logic [63:0] get_od(int k);
    case (k)
      0: return d0_odat;
      1: return d1_odat;
      2: return d2_odat;
      default: return {32'h0, d3_odat};
    endcase
  endfunction

  // Waits for out_valid, counting edges after the accept edge.
  task automatic wait_result(input int k, input string tag, input int g, input logic dec,
                             input bit toggle, output logic [63:0] res);
    int cyc;
    logic cur;
    cyc = 0;
    cur = dec;
    while (!get_ov(k) && cyc < 200) begin
      if (toggle) cur = ~cur;
      drive(k, 1'b0, cur, 64'h0, 1'b1);
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(g));
    res = get_od(k);
    drive(k, 1'b0, 1'b0, 64'h0, 1'b1);
  endtask

  task automatic run_op(input int k, input string tag, input logic [63:0] d, input logic dec,
                        input int g, input bit toggle, output logic [63:0] res);
    @(negedge clk);
    drive(k, 1'b1, dec, d, 1'b1);
    #1;
    check({tag, "_in_ready"}, 64'(get_ir(k)), 64'h1);
    @(negedge clk);
    wait_result(k, tag, g, dec, toggle, res);
  endtask

  logic [63:0] r, r2, x, y, hold;
  int cyc;
  int nib_of [4] = '{16, 16, 16, 8};
  int grp_of [4] = '{4, 16, 1, 4};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(d0_ov), 64'h0);
    check("rst_out_data", d0_odat, 64'h0);
    check("rst_in_ready", 64'(d0_ir), 64'h1);
    rst = 1'b0;

    run_op(0, "fwd_vec", 64'h0123456789ABCDEF, 1'b0, 4, 1'b0, r);
    check("fwd_vec_data", r, 64'hBF32AC916780E5D4);
    run_op(0, "inv_vec", 64'hBF32AC916780E5D4, 1'b1, 4, 1'b0, r);
    check("inv_vec_data", r, 64'h0123456789ABCDEF);
    run_op(0, "fwd_zero", 64'h0, 1'b0, 4, 1'b0, r);
    check("fwd_zero_data", r, 64'hBBBBBBBBBBBBBBBB);
    run_op(0, "inv_zero", 64'h0, 1'b1, 4, 1'b0, r);
    check("inv_zero_data", r, 64'hBBBBBBBBBBBBBBBB);

    // Backpressure in DONE, then back-to-back accept.
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    @(negedge clk);
    drive(0, 1'b1, 1'b0, x, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'h0, 1'b0);
    cyc = 0;
    while (!d0_ov && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_latency", 64'(cyc), 64'd4);
    hold = d0_odat;
    check("bp_data", hold, model(x, 16, 1'b0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(d0_ov), 64'h1);
      check("bp_hold_data", d0_odat, hold);
      check("bp_hold_in_ready", 64'(d0_ir), 64'h0);
    end
    drive(0, 1'b1, 1'b1, y, 1'b1);
    #1;
    check("b2b_in_ready", 64'(d0_ir), 64'h1);
    @(negedge clk);
    check("b2b_valid_drop", 64'(d0_ov), 64'h0);
    wait_result(0, "b2b", 4, 1'b1, 1'b0, r);
    check("b2b_data", r, model(y, 16, 1'b1));

    // Reset two cycles after accept.
    x = {$urandom, $urandom};
    @(negedge clk);
    drive(0, 1'b1, 1'b0, x, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'h0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(d0_ov), 64'h0);
    check("midrst_out_data", d0_odat, 64'h0);
    check("midrst_in_ready", 64'(d0_ir), 64'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("postrst_no_valid", 64'(d0_ov), 64'h0);
    end
    y = {$urandom, $urandom};
    run_op(0, "postrst", y, 1'b0, 4, 1'b0, r);
    check("postrst_data", r, model(y, 16, 1'b0));

    // Mode toggled every cycle while busy.
    x = {$urandom, $urandom};
    run_op(0, "iso_fwd", x, 1'b0, 4, 1'b1, r);
    check("iso_fwd_data", r, model(x, 16, 1'b0));
    run_op(0, "iso_inv", x, 1'b1, 4, 1'b1, r);
    check("iso_inv_data", r, model(x, 16, 1'b1));

    // Parameter sweep: random operands, both modes, round trip.
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 5; n++) begin
        x = {$urandom, $urandom};
        if (nib_of[k] == 8) x = x & 64'hFFFF_FFFF;
        run_op(k, "sweep_fwd", x, 1'b0, grp_of[k], 1'b0, r);
        check("sweep_fwd_data", r, model(x, nib_of[k], 1'b0));
        run_op(k, "sweep_rt", r, 1'b1, grp_of[k], 1'b0, r2);
        check("sweep_roundtrip", r2, x);
        run_op(k, "sweep_inv", x, 1'b1, grp_of[k], 1'b0, r);
        check("sweep_inv_data", r, model(x, nib_of[k], 1'b1));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
